pixel_window_3x3: RTL and testbench
===================================

Name: pixel_window_3x3

Overview:
- Raster-scan pixel streamer that builds the 3x3 neighbourhood consumed by the canny Sobel gradient stage.
- Accepts one pixel per valid cycle and keeps two line buffers.
- Presents im11..im33 plus a one-cycle start strobe for each complete interior window.
- Sits directly upstream of canny. win_valid drives canny.start; window outputs drive im11..im33.

Parameters:
- IMG_WIDTH, 640, pixels per line (>=3).
- IMG_HEIGHT, 480, lines per frame (>=3).
- PIX_W, 16, pixel width in bits.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-low reset.
- pix_valid  in  1  pix_in is valid this cycle.
- pix_in  in  PIX_W  raster-order pixel.
- sof  in  1  start-of-frame; qualified by pix_valid; marks pixel (0,0).
- im11..im33  out  PIX_W each  window; im{r}{c}, r=1 is line row-2, r=3 is current line, c=1 is column col-2, c=3 is column col.
- win_valid  out  1  window valid strobe.
- frame_done  out  1  one-cycle pulse with the window of the last frame pixel.

Behaviour:
- Reset: reset is synchronous, active-low; clock is clk.
  - While reset=0: all outputs are 0, col=0, row=0, shift registers are 0.
  - Line-buffer contents are don't-care.
- Counters:
  - col counts 0..IMG_WIDTH-1; row counts 0..IMG_HEIGHT-1.
  - Counter width is clog2 of the respective dimension.
  - Both advance only on pix_valid=1.
- Line buffers:
  - lb0 delays the current line by IMG_WIDTH accepted pixels; lb1 delays lb0's output by IMG_WIDTH.
  - Each lb is written and read once per accepted pixel at a circular pointer equal to col.
- Window shift: on an accepted pixel, the shift registers move left (c3->c2->c1).
  - Column 3 loads from top lb1 out, middle lb0 out, bottom pix_in.
- Output update: outputs are registered. One cycle after pixel (row,col) is accepted:
  - Window registers show the 3x3 window ending at (row,col).
  - win_valid=1 iff row>=2 and col>=2.
- Window count: (IMG_WIDTH-2)*(IMG_HEIGHT-2) windows per frame.
- Idle cycles (pix_valid=0): win_valid=0 next cycle; window outputs hold their last value; counters hold.
- win_valid is never high on two cycles unless pixels were accepted on two consecutive cycles.
- Line wrap: at col=IMG_WIDTH-1, col goes to 0 and row increments.
  - No window spans a line wrap, because of the col>=2 condition.
- Frame end: at (IMG_HEIGHT-1, IMG_WIDTH-1), frame_done=1 in the same cycle as that pixel's win_valid, then row=col=0.
- sof=1 with pix_valid=1: the pixel is treated as (0,0) regardless of counter state and the counters restart.
  - Stale line-buffer data is harmless; no window is emitted until row 2.
- sof with pix_valid=0: ignored.
- Reset mid-frame: pipeline is abandoned and no partial frame_done occurs. The next accepted pixel is (0,0).
- No backpressure: the downstream stage accepts every window.

Optional Feature:
- Macro: PIXWIN_SOF_CHECK_EN.
- Defined:
  - Adds output sof_err (1 bit).
  - sof_err goes sticky high one cycle after an accepted sof where (row,col)!=(0,0) before the restart.
  - sof_err is cleared only by reset; reset value is 0.
  - Restart behaviour is unchanged.
- Undefined: the port is absent; there is no checking logic.

Decomposition:
- Package pixwin_pkg holds:
  - the clog2-based width helper function;
  - the default PIX_W constant;
  - the window index localparams.
- Sub-module pixwin_line_buffer:
  - parameters DEPTH and W;
  - ports clk, en, wr_ptr, din, dout;
  - read-before-write single-port RAM behaviour with one-cycle delay aligned to en.
  - Instantiated twice (lb0, lb1).

Test Plan (IMG_WIDTH=4, IMG_HEIGHT=4 unless noted; pixel value = 16*row+col):
- Continuous frame, sof on the first pixel:
  - exactly 4 win_valid pulses;
  - first window, one cycle after pixel 0x22: im11=0x00, im12=0x01, im13=0x02, im21=0x10, im22=0x11, im23=0x12, im31=0x20, im32=0x21, im33=0x22;
  - last window is im11=0x11 .. im33=0x33 with frame_done=1.
- Same frame with pix_valid randomly low about 50% of cycles:
  - identical window sequence;
  - win_valid only in the cycle after accepted pixels 0x22, 0x23, 0x32, 0x33;
  - outputs hold during gaps.
- Two back-to-back frames without idle: the second frame yields the same 4 windows and a second frame_done; no window mixes data from both frames.
- sof asserted at pixel (1,3) of frame one, then a full frame:
  - no window before new row 2;
  - 4 correct windows;
  - with PIXWIN_SOF_CHECK_EN, sof_err=1 and it stays high.
- reset=0 for one cycle after pixel (2,2) is accepted:
  - all outputs 0 next cycle;
  - no frame_done;
  - a following full frame behaves as in scenario 1.
- IMG_WIDTH=640, IMG_HEIGHT=480 full frame: 638*478=304964 win_valid pulses and exactly one frame_done.

Source files
------------

// File: rtl/pixel_window_3x3_pkg.sv
// rtl/pixel_window_3x3_pkg.sv - shared constants and helpers for the 3x3 pixel window
//
// Package pixwin_pkg:
//   PIX_W_DEFAULT  default pixel width
//   W11..W33       index of each window tap in the flattened 3x3 window array
//   cnt_width()    counter width for a dimension (clog2, minimum 1)
package pixwin_pkg;

  localparam int PIX_W_DEFAULT = 16;

  // Window taps, row-major: W<r><c>, r=1 oldest line, c=1 oldest column.
  localparam int W11 = 0;
  localparam int W12 = 1;
  localparam int W13 = 2;
  localparam int W21 = 3;
  localparam int W22 = 4;
  localparam int W23 = 5;
  localparam int W31 = 6;
  localparam int W32 = 7;
  localparam int W33 = 8;
  localparam int WIN_N = 9;

  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pixel_window_3x3_if.sv
// rtl/pixel_window_3x3_if.sv - pixel stream in / 3x3 window out bundle
//
// Signals:
//   pix_valid, pix_in, sof      raster pixel stream into the window builder
//   im11..im33                  window taps
//   win_valid                   one-cycle strobe per complete interior window
//   frame_done                  pulse with the window of the last frame pixel
//   sof_err                     sticky misplaced-sof flag (PIXWIN_SOF_CHECK_EN only)
// Modports:
//   master  pixel source / window consumer side
//   slave   window builder side
interface pixel_window_3x3_if
  import pixwin_pkg::*;
#(
  parameter int PIX_W = PIX_W_DEFAULT
);

  logic             pix_valid;
  logic [PIX_W-1:0] pix_in;
  logic             sof;
  logic [PIX_W-1:0] im11, im12, im13;
  logic [PIX_W-1:0] im21, im22, im23;
  logic [PIX_W-1:0] im31, im32, im33;
  logic             win_valid;
  logic             frame_done;
`ifdef PIXWIN_SOF_CHECK_EN
  logic             sof_err;
`endif

  modport master (
    output pix_valid, pix_in, sof,
`ifdef PIXWIN_SOF_CHECK_EN
    input  sof_err,
`endif
    input  im11, im12, im13, im21, im22, im23, im31, im32, im33,
    input  win_valid, frame_done
  );

  modport slave (
    input  pix_valid, pix_in, sof,
`ifdef PIXWIN_SOF_CHECK_EN
    output sof_err,
`endif
    output im11, im12, im13, im21, im22, im23, im31, im32, im33,
    output win_valid, frame_done
  );

endinterface

// File: rtl/pixwin_line_buffer.sv
// rtl/pixwin_line_buffer.sv - one-line circular delay for the window builder
//
// Ports:
//   clk     clock
//   en      accepted-pixel strobe; the write happens only on en
//   wr_ptr  circular pointer (current column)
//   din     word entering the line
//   dout    word stored at wr_ptr one line ago
module pixwin_line_buffer
  import pixwin_pkg::*;
#(
  parameter int DEPTH = 640,
  parameter int W     = 16,
  localparam int PTR_W = cnt_width(DEPTH)
) (
  input  logic             clk,
  input  logic             en,
  input  logic [PTR_W-1:0] wr_ptr,
  input  logic [W-1:0]     din,
  output logic [W-1:0]     dout
);

  logic [W-1:0] mem_q [DEPTH];

  // Read returns the old word at wr_ptr in the accepting cycle; the new word
  // lands at the clock edge, so every slot delays by exactly DEPTH accepts.
  assign dout = mem_q[wr_ptr];

  always_ff @(posedge clk) begin
    if (en) begin
      mem_q[wr_ptr] <= din;
    end
  end

endmodule

// File: rtl/pixel_window_3x3.sv
// rtl/pixel_window_3x3.sv - raster pixel stream to registered 3x3 neighbourhood
//
// Ports:
//   clk    clock
//   reset  synchronous, active-low reset
//   bus    pixel_window_3x3_if.slave: pixel stream in, window/strobes out
// Optional: define PIXWIN_SOF_CHECK_EN to add the sticky sof_err output.
module pixel_window_3x3
  import pixwin_pkg::*;
#(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int PIX_W      = PIX_W_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  pixel_window_3x3_if.slave bus
);

  localparam int COL_W = cnt_width(IMG_WIDTH);
  localparam int ROW_W = cnt_width(IMG_HEIGHT);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);
  localparam logic [COL_W-1:0] COL_TWO  = COL_W'(2);
  localparam logic [ROW_W-1:0] ROW_TWO  = ROW_W'(2);

  logic [COL_W-1:0] col_q, col_d, cur_col;
  logic [ROW_W-1:0] row_q, row_d, cur_row;
  logic [PIX_W-1:0] win_q [WIN_N];
  logic [PIX_W-1:0] win_d [WIN_N];
  logic             win_valid_q, win_valid_d;
  logic             frame_done_q, frame_done_d;
  logic [PIX_W-1:0] lb0_out, lb1_out;
  logic             accept, restart;

  assign accept  = bus.pix_valid;
  assign restart = bus.pix_valid & bus.sof;

  // An accepted sof forces this pixel to (0,0) whatever the counters say.
  assign cur_col = restart ? '0 : col_q;
  assign cur_row = restart ? '0 : row_q;

  pixwin_line_buffer #(.DEPTH(IMG_WIDTH), .W(PIX_W)) lb0 (
    .clk    (clk),
    .en     (accept),
    .wr_ptr (cur_col),
    .din    (bus.pix_in),
    .dout   (lb0_out)
  );

  pixwin_line_buffer #(.DEPTH(IMG_WIDTH), .W(PIX_W)) lb1 (
    .clk    (clk),
    .en     (accept),
    .wr_ptr (cur_col),
    .din    (lb0_out),
    .dout   (lb1_out)
  );

  always_comb begin
    col_d        = col_q;
    row_d        = row_q;
    win_d        = win_q;
    win_valid_d  = 1'b0;
    frame_done_d = 1'b0;
    if (accept) begin
      if (cur_col == COL_LAST) begin
        col_d = '0;
        row_d = (cur_row == ROW_LAST) ? '0 : cur_row + 1'b1;
      end else begin
        col_d = cur_col + 1'b1;
        row_d = cur_row;
      end
      for (int r = 0; r < 3; r++) begin
        win_d[3*r]     = win_q[3*r + 1];
        win_d[3*r + 1] = win_q[3*r + 2];
      end
      win_d[W13]   = lb1_out;
      win_d[W23]   = lb0_out;
      win_d[W33]   = bus.pix_in;
      // col>=2 also guarantees no window straddles a line wrap.
      win_valid_d  = (cur_row >= ROW_TWO) && (cur_col >= COL_TWO);
      frame_done_d = (cur_row == ROW_LAST) && (cur_col == COL_LAST);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      col_q        <= '0;
      row_q        <= '0;
      win_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      for (int i = 0; i < WIN_N; i++) begin
        win_q[i] <= '0;
      end
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      win_valid_q  <= win_valid_d;
      frame_done_q <= frame_done_d;
      win_q        <= win_d;
    end
  end

  assign bus.im11       = win_q[W11];
  assign bus.im12       = win_q[W12];
  assign bus.im13       = win_q[W13];
  assign bus.im21       = win_q[W21];
  assign bus.im22       = win_q[W22];
  assign bus.im23       = win_q[W23];
  assign bus.im31       = win_q[W31];
  assign bus.im32       = win_q[W32];
  assign bus.im33       = win_q[W33];
  assign bus.win_valid  = win_valid_q;
  assign bus.frame_done = frame_done_q;

`ifdef PIXWIN_SOF_CHECK_EN
  logic sof_err_q, sof_err_d;

  // Uses the raw counters: the flag means sof arrived somewhere other than (0,0).
  always_comb begin
    sof_err_d = sof_err_q | (restart & ((row_q != '0) | (col_q != '0)));
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      sof_err_q <= 1'b0;
    end else begin
      sof_err_q <= sof_err_d;
    end
  end

  assign bus.sof_err = sof_err_q;
`endif

endmodule

// File: tb/tb_pixel_window_3x3.sv
// tb/tb_pixel_window_3x3.sv - directed self-checking bench for pixel_window_3x3 (4x4 frame)
module tb_pixel_window_3x3;

  localparam logic [143:0] FIRST_WIN = 144'h0000_0001_0002_0010_0011_0012_0020_0021_0022;
  localparam logic [143:0] LAST_WIN  = 144'h0011_0012_0013_0021_0022_0023_0031_0032_0033;

  logic clk;
  logic reset;
  int   n_pass;
  int   n_total;

  pixel_window_3x3_if #(.PIX_W(16)) bus ();

  pixel_window_3x3 #(.IMG_WIDTH(4), .IMG_HEIGHT(4), .PIX_W(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [143:0] win_all;
  assign win_all = {bus.im11, bus.im12, bus.im13, bus.im21, bus.im22, bus.im23,
                    bus.im31, bus.im32, bus.im33};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] pix(input int r, input int c);
    return 16'(16 * r + c);
  endfunction

  // Window ending at (r,c) of a frame whose pixel value is 16*row+col.
  function automatic logic [143:0] exp_win(input int r, input int c);
    logic [143:0] w;
    w = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        w[(8 - (3 * i + j)) * 16 +: 16] = pix(r - 2 + i, c - 2 + j);
    return w;
  endfunction

  task automatic step(input logic v, input logic s, input logic [15:0] p);
    @(negedge clk);
    bus.pix_valid = v;
    bus.sof       = s;
    bus.pix_in    = p;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    step(1'b0, 1'b0, 16'h0);
    step(1'b1, 1'b1, 16'h55);
    n_total++;
    if ({win_all, bus.win_valid, bus.frame_done} !== 146'h0)
      $display("FAIL reset_outputs got %h expected 0", {win_all, bus.win_valid, bus.frame_done});
    else n_pass++;
`ifdef PIXWIN_SOF_CHECK_EN
    n_total++;
    if (bus.sof_err !== 1'b0) $display("FAIL reset_sof_err got %b expected 0", bus.sof_err);
    else n_pass++;
`endif
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_continuous();
    int nw, nd;
    nw = 0;
    nd = 0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        step(1'b1, (r == 0 && c == 0), pix(r, c));
        n_total++;
        if (bus.win_valid !== (r >= 2 && c >= 2))
          $display("FAIL cont_win_valid (%0d,%0d) got %b expected %b", r, c, bus.win_valid, (r >= 2 && c >= 2));
        else n_pass++;
        if (bus.win_valid === 1'b1) nw++;
        if (bus.frame_done === 1'b1) nd++;
        if (r == 2 && c == 2) begin
          n_total++;
          if (win_all !== FIRST_WIN) $display("FAIL cont_first_window got %h expected %h", win_all, FIRST_WIN);
          else n_pass++;
        end
        if (r >= 2 && c >= 2) begin
          n_total++;
          if (win_all !== exp_win(r, c))
            $display("FAIL cont_window (%0d,%0d) got %h expected %h", r, c, win_all, exp_win(r, c));
          else n_pass++;
        end
        if (r == 3 && c == 3) begin
          n_total++;
          if (bus.frame_done !== 1'b1 || win_all !== LAST_WIN)
            $display("FAIL cont_last_window done=%b got %h expected done=1 %h", bus.frame_done, win_all, LAST_WIN);
          else n_pass++;
        end
      end
    end
    n_total++;
    if (nw != 4 || nd != 1) $display("FAIL cont_counts windows=%0d done=%0d expected 4 and 1", nw, nd);
    else n_pass++;
    step(1'b0, 1'b0, 16'hdead);
    n_total++;
    if (bus.win_valid !== 1'b0 || bus.frame_done !== 1'b0 || win_all !== LAST_WIN)
      $display("FAIL cont_idle_hold valid=%b done=%b got %h expected 0 0 %h", bus.win_valid, bus.frame_done, win_all, LAST_WIN);
    else n_pass++;
`ifdef PIXWIN_SOF_CHECK_EN
    n_total++;
    if (bus.sof_err !== 1'b0) $display("FAIL cont_sof_err got %b expected 0", bus.sof_err);
    else n_pass++;
`endif
  endtask

  task automatic test_gaps();
    int nw, lr, lc, k;
    nw = 0;
    lr = 0;
    lc = 0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        k = 0;
        // Idle cycles drive sof=1 to show it is ignored without pix_valid.
        while ((c == 3 && k == 0) || ($urandom_range(0, 1) == 1 && k < 3)) begin
          step(1'b0, 1'b1, 16'hbeef);
          k++;
          n_total++;
          if (bus.win_valid !== 1'b0 || bus.frame_done !== 1'b0)
            $display("FAIL gap_idle_strobe before (%0d,%0d) valid=%b done=%b expected 0 0", r, c, bus.win_valid, bus.frame_done);
          else n_pass++;
          if (lr >= 2 && lc >= 2) begin
            n_total++;
            if (win_all !== exp_win(lr, lc))
              $display("FAIL gap_hold before (%0d,%0d) got %h expected %h", r, c, win_all, exp_win(lr, lc));
            else n_pass++;
          end
        end
        step(1'b1, (r == 0 && c == 0), pix(r, c));
        lr = r;
        lc = c;
        n_total++;
        if (bus.win_valid !== (r >= 2 && c >= 2) || bus.frame_done !== (r == 3 && c == 3))
          $display("FAIL gap_strobes (%0d,%0d) valid=%b done=%b", r, c, bus.win_valid, bus.frame_done);
        else n_pass++;
        if (bus.win_valid === 1'b1) begin
          nw++;
          n_total++;
          if (win_all !== exp_win(r, c))
            $display("FAIL gap_window (%0d,%0d) got %h expected %h", r, c, win_all, exp_win(r, c));
          else n_pass++;
        end
      end
    end
    n_total++;
    if (nw != 4) $display("FAIL gap_count windows=%0d expected 4", nw);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int nw, nd;
    nw = 0;
    nd = 0;
    for (int f = 0; f < 2; f++) begin
      for (int r = 0; r < 4; r++) begin
        for (int c = 0; c < 4; c++) begin
          step(1'b1, (r == 0 && c == 0), pix(r, c));
          if (bus.win_valid === 1'b1) nw++;
          if (bus.frame_done === 1'b1) nd++;
          n_total++;
          if (bus.win_valid !== (r >= 2 && c >= 2))
            $display("FAIL b2b_win_valid f%0d (%0d,%0d) got %b", f, r, c, bus.win_valid);
          else n_pass++;
          if (r >= 2 && c >= 2) begin
            n_total++;
            if (win_all !== exp_win(r, c))
              $display("FAIL b2b_window f%0d (%0d,%0d) got %h expected %h", f, r, c, win_all, exp_win(r, c));
            else n_pass++;
          end
        end
      end
    end
    n_total++;
    if (nw != 8 || nd != 2) $display("FAIL b2b_counts windows=%0d done=%0d expected 8 and 2", nw, nd);
    else n_pass++;
  endtask

  task automatic test_sof_restart();
    int nw, nd;
    nw = 0;
    nd = 0;
    for (int i = 0; i < 7; i++) begin
      step(1'b1, (i == 0), pix(i / 4, i % 4));
      if (bus.win_valid === 1'b1) nw++;
    end
`ifdef PIXWIN_SOF_CHECK_EN
    n_total++;
    if (bus.sof_err !== 1'b0) $display("FAIL sof_err_before got %b expected 0", bus.sof_err);
    else n_pass++;
`endif
    // The would-be pixel (1,3) carries sof and starts a fresh frame.
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        step(1'b1, (r == 0 && c == 0), pix(r, c));
        if (bus.win_valid === 1'b1) nw++;
        if (bus.frame_done === 1'b1) nd++;
        n_total++;
        if (bus.win_valid !== (r >= 2 && c >= 2))
          $display("FAIL sof_win_valid (%0d,%0d) got %b", r, c, bus.win_valid);
        else n_pass++;
        if (r >= 2 && c >= 2) begin
          n_total++;
          if (win_all !== exp_win(r, c))
            $display("FAIL sof_window (%0d,%0d) got %h expected %h", r, c, win_all, exp_win(r, c));
          else n_pass++;
        end
`ifdef PIXWIN_SOF_CHECK_EN
        n_total++;
        if (bus.sof_err !== 1'b1) $display("FAIL sof_err_sticky (%0d,%0d) got %b expected 1", r, c, bus.sof_err);
        else n_pass++;
`endif
      end
    end
    n_total++;
    if (nw != 4 || nd != 1) $display("FAIL sof_counts windows=%0d done=%0d expected 4 and 1", nw, nd);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int nw, nd;
    for (int i = 0; i < 11; i++) step(1'b1, (i == 0), pix(i / 4, i % 4));
    n_total++;
    if (bus.win_valid !== 1'b1 || win_all !== FIRST_WIN)
      $display("FAIL rstmid_pre valid=%b got %h expected 1 %h", bus.win_valid, win_all, FIRST_WIN);
    else n_pass++;
    @(negedge clk);
    reset = 1'b0;
    bus.pix_valid = 1'b0;
    bus.sof = 1'b0;
    @(posedge clk);
    #1;
    n_total++;
    if ({win_all, bus.win_valid, bus.frame_done} !== 146'h0)
      $display("FAIL rstmid_outputs got %h expected 0", {win_all, bus.win_valid, bus.frame_done});
    else n_pass++;
`ifdef PIXWIN_SOF_CHECK_EN
    n_total++;
    if (bus.sof_err !== 1'b0) $display("FAIL rstmid_sof_err got %b expected 0", bus.sof_err);
    else n_pass++;
`endif
    @(negedge clk);
    reset = 1'b1;
    nw = 0;
    nd = 0;
    // No sof: the counters alone must restart at (0,0).
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        step(1'b1, 1'b0, pix(r, c));
        if (bus.win_valid === 1'b1) nw++;
        if (bus.frame_done === 1'b1) nd++;
        n_total++;
        if (bus.frame_done !== (r == 3 && c == 3))
          $display("FAIL rstmid_frame_done (%0d,%0d) got %b", r, c, bus.frame_done);
        else n_pass++;
        if (r >= 2 && c >= 2) begin
          n_total++;
          if (bus.win_valid !== 1'b1 || win_all !== exp_win(r, c))
            $display("FAIL rstmid_window (%0d,%0d) valid=%b got %h expected %h", r, c, bus.win_valid, win_all, exp_win(r, c));
          else n_pass++;
        end
      end
    end
    n_total++;
    if (nw != 4 || nd != 1) $display("FAIL rstmid_counts windows=%0d done=%0d expected 4 and 1", nw, nd);
    else n_pass++;
  endtask

  initial begin
    n_pass = 0;
    n_total = 0;
    reset = 1'b0;
    bus.pix_valid = 1'b0;
    bus.sof = 1'b0;
    bus.pix_in = '0;
    test_reset();
    test_continuous();
    test_gaps();
    test_back_to_back();
    test_sof_restart();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
